// File: rtl/byte_deserializer_pkg.sv
// Shared types and constants for the byte deserializer slice.
package byte_deserializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam int   DATA_BITS  = 8;
    localparam int   CNT_W      = 3;
    localparam logic STOP_LEVEL = 1'b1;

    // Even parity of a data byte: the parity bit a sender must append.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/byte_deserializer_if.sv
// Serial input strobe/data and received-byte outputs of the deserializer.
interface byte_deserializer_if;
    import byte_deserializer_pkg::*;

    logic                 bit_valid;
    logic                 sin;
    logic [DATA_BITS-1:0] data_out;
    logic                 load_en;
    logic                 busy;
    logic                 parity_err;
    logic                 frame_err;

    modport master (
        output bit_valid, sin,
        input  data_out, load_en, busy, parity_err, frame_err
    );

    modport slave (
        input  bit_valid, sin,
        output data_out, load_en, busy, parity_err, frame_err
    );
endinterface

// File: rtl/byte_deserializer_frame_shifter.sv
// LSB-first shift register collecting data bits, with its running even parity.
module byte_deserializer_frame_shifter
    import byte_deserializer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 shift_en_i,
    input  logic                 bit_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 parity_o
);

    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] shreg_d;

    // Next value: new bit enters at the MSB so the first bit ends up in bit 0.
    always_comb begin
        shreg_d = shreg_q;
        if (shift_en_i) begin
            shreg_d = {bit_i, shreg_q[DATA_BITS-1:1]};
        end else begin
            shreg_d = shreg_q;
        end
    end

    // Shift register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign data_o   = shreg_q;
    assign parity_o = even_parity(shreg_q);

endmodule

// File: rtl/byte_deserializer.sv
// Receives start/8 data/optional even parity/stop frames sampled on bit_valid
// strobes and presents good bytes with a one-cycle load pulse.
module byte_deserializer
    import byte_deserializer_pkg::*;
#(
    parameter bit PARITY_EN = 1'b1
)
(
    input  logic         clk,
    input  logic         rst_n,
    byte_deserializer_if.slave bus
);

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 par_mis_q;
    logic [DATA_BITS-1:0] data_out_q;
    logic                 load_en_q;
    logic                 busy_q;
    logic                 parity_err_q;
    logic                 frame_err_q;

    logic                 shift_en_s;
    logic [DATA_BITS-1:0] sh_data_s;
    logic                 sh_parity_s;

    assign shift_en_s = bus.bit_valid && (state_q == DATA);

    byte_deserializer_frame_shifter u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en_i (shift_en_s),
        .bit_i      (bus.sin),
        .data_o     (sh_data_s),
        .parity_o   (sh_parity_s)
    );

    // Frame FSM plus registered outputs; pulses default low every cycle and
    // are only raised on the stop sample, so load and errors share one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            par_mis_q    <= 1'b0;
            data_out_q   <= '0;
            load_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            load_en_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (bus.bit_valid) begin
                case (state_q)
                    IDLE: begin
                        if (bus.sin == 1'b0) begin
                            state_q   <= DATA;
                            cnt_q     <= '0;
                            par_mis_q <= 1'b0;
                            busy_q    <= 1'b1;
                        end else begin
                            state_q   <= IDLE;
                        end
                    end
                    DATA: begin
                        // Counter wraps 7 -> 0 on the same sample that leaves DATA.
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                            state_q <= PARITY_EN ? PARITY : STOP;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                    PARITY: begin
                        par_mis_q <= bus.sin ^ sh_parity_s;
                        state_q   <= STOP;
                    end
                    STOP: begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        frame_err_q  <= (bus.sin != STOP_LEVEL);
                        parity_err_q <= par_mis_q;
                        if ((bus.sin == STOP_LEVEL) && !par_mis_q) begin
                            data_out_q <= sh_data_s;
                            load_en_q  <= 1'b1;
                        end else begin
                            data_out_q <= data_out_q;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end else begin
                state_q <= state_q;
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.load_en    = load_en_q;
    assign bus.busy       = busy_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_byte_deserializer.sv
// Self-checking bench: one parity-enabled and one parity-less deserializer,
// a frame table driven into a scoreboard, plus hand-written corner sequences.
module tb_byte_deserializer;
    import byte_deserializer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic vp = 1'b0, sp = 1'b1, vn = 1'b0, sn = 1'b1;

    byte_deserializer_if bus_p ();
    byte_deserializer_if bus_n ();

    assign bus_p.bit_valid = vp;
    assign bus_p.sin       = sp;
    assign bus_n.bit_valid = vn;
    assign bus_n.sin       = sn;

    byte_deserializer #(.PARITY_EN(1'b1)) dut_p (.clk(clk), .rst_n(rst_n), .bus(bus_p.slave));
    byte_deserializer #(.PARITY_EN(1'b0)) dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n.slave));

    typedef struct {
        int         exp_pc;
        logic       load;
        logic       perr;
        logic       ferr;
        logic [7:0] dout;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stop;
        int         gap;
        int         stretch;
        logic       load;
        logic       perr;
        logic       ferr;
        logic [7:0] dout;
    } vec_t;

    exp_t q_p[$];
    exp_t q_n[$];
    int   total = 0;
    int   bad   = 0;
    int   pc    = 0;

    always @(posedge clk) pc <= pc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard for the parity-enabled instance.
    always @(negedge clk) begin
        if (rst_n && (bus_p.load_en || bus_p.parity_err || bus_p.frame_err)) begin
            if (q_p.size() == 0) begin
                check("p_unexpected_pulse", {29'd0, bus_p.load_en, bus_p.parity_err, bus_p.frame_err}, 32'd0);
            end else begin
                exp_t e;
                e = q_p.pop_front();
                check("p_cycle", pc, e.exp_pc);
                check("p_load_en", bus_p.load_en, e.load);
                check("p_parity_err", bus_p.parity_err, e.perr);
                check("p_frame_err", bus_p.frame_err, e.ferr);
                check("p_data_out", bus_p.data_out, e.dout);
            end
        end
    end

    // Scoreboard for the parity-less instance.
    always @(negedge clk) begin
        if (rst_n && (bus_n.load_en || bus_n.parity_err || bus_n.frame_err)) begin
            if (q_n.size() == 0) begin
                check("n_unexpected_pulse", {29'd0, bus_n.load_en, bus_n.parity_err, bus_n.frame_err}, 32'd0);
            end else begin
                exp_t e;
                e = q_n.pop_front();
                check("n_cycle", pc, e.exp_pc);
                check("n_load_en", bus_n.load_en, e.load);
                check("n_parity_err", bus_n.parity_err, e.perr);
                check("n_frame_err", bus_n.frame_err, e.ferr);
                check("n_data_out", bus_n.data_out, e.dout);
            end
        end
    end

    task automatic drive(input bit which, input logic v, input logic s);
        if (which) begin
            vn = v;
            sn = s;
        end else begin
            vp = v;
            sp = s;
        end
    endtask

    task automatic idle(input bit which, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(which, 1'b0, 1'b1);
        end
    endtask

    task automatic send_bit(input bit which, input logic b, input int stretch);
        @(negedge clk);
        drive(which, 1'b1, b);
        for (int k = 0; k < stretch; k++) begin
            @(negedge clk);
            drive(which, 1'b0, 1'($urandom_range(1, 0)));
        end
    endtask

    // Drives a whole frame; returns the cycle count at which the stop bit was presented.
    task automatic send_frame(input bit which, input logic [7:0] d, input bit has_par,
                              input logic par, input logic stop, input int stretch,
                              output int stop_pc);
        send_bit(which, 1'b0, stretch);
        for (int i = 0; i < 8; i++) send_bit(which, d[i], stretch);
        if (has_par) send_bit(which, par, stretch);
        @(negedge clk);
        drive(which, 1'b1, stop);
        stop_pc = pc;
    endtask

    task automatic push_exp(input bit which, input int stop_pc, input logic load,
                            input logic perr, input logic ferr, input logic [7:0] dout);
        exp_t e;
        e.exp_pc = stop_pc + 1;
        e.load   = load;
        e.perr   = perr;
        e.ferr   = ferr;
        e.dout   = dout;
        if (which) q_n.push_back(e);
        else       q_p.push_back(e);
    endtask

    vec_t vecs[8];

    initial begin
        int spc;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 2, 0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{8'h07, 1'b0, 1'b1, 2, 0, 1'b0, 1'b1, 1'b0, 8'hA5};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 2, 0, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[3] = '{8'h80, 1'b0, 1'b0, 1, 0, 1'b0, 1'b1, 1'b1, 8'hA5};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 1, 2, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[5] = '{8'hFE, 1'b1, 1'b1, 1, 0, 1'b1, 1'b0, 1'b0, 8'hFE};
        vecs[6] = '{8'h11, 1'b0, 1'b1, 1, 0, 1'b1, 1'b0, 1'b0, 8'h11};
        vecs[7] = '{8'hEE, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 8'hEE};

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("p_rst_data_out", bus_p.data_out, 32'h0);
        check("p_rst_load_en", bus_p.load_en, 32'd0);
        check("p_rst_busy", bus_p.busy, 32'd0);
        check("p_rst_parity_err", bus_p.parity_err, 32'd0);
        check("p_rst_frame_err", bus_p.frame_err, 32'd0);
        check("n_rst_data_out", bus_n.data_out, 32'h0);
        check("n_rst_busy", bus_n.busy, 32'd0);
        rst_n = 1'b1;

        // Table of frames into the parity instance.
        for (int i = 0; i < 8; i++) begin
            idle(1'b0, vecs[i].gap);
            send_frame(1'b0, vecs[i].d, 1'b1, vecs[i].par, vecs[i].stop, vecs[i].stretch, spc);
            push_exp(1'b0, spc, vecs[i].load, vecs[i].perr, vecs[i].ferr, vecs[i].dout);
        end
        idle(1'b0, 3);
        check("p_dout_after_table", bus_p.data_out, 32'hEE);

        // Mid-frame reset after four data bits of 0xFF.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("p_busy_after_start", bus_p.busy, 32'd1);
        drive(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1, 0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1);
        check("p_busy_mid_frame", bus_p.busy, 32'd1);
        rst_n = 1'b0;
        #1;
        check("p_midrst_data_out", bus_p.data_out, 32'h0);
        check("p_midrst_busy", bus_p.busy, 32'd0);
        check("p_midrst_flags", {29'd0, bus_p.load_en, bus_p.parity_err, bus_p.frame_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0, 1);
        send_frame(1'b0, 8'h5A, 1'b1, 1'b0, 1'b1, 0, spc);
        push_exp(1'b0, spc, 1'b1, 1'b0, 1'b0, 8'h5A);
        check("p_busy_stop_cycle", bus_p.busy, 32'd1);
        idle(1'b0, 1);
        check("p_busy_after_stop", bus_p.busy, 32'd0);
        idle(1'b0, 2);

        // Parity-less instance: idle noise, then 0x81 without a parity bit.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("n_busy_idle_noise", bus_n.busy, 32'd0);
            drive(1'b1, 1'b1, 1'b1);
        end
        send_frame(1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 0, spc);
        push_exp(1'b1, spc, 1'b1, 1'b0, 1'b0, 8'h81);
        idle(1'b1, 4);

        check("p_queue_empty", q_p.size(), 32'd0);
        check("n_queue_empty", q_n.size(), 32'd0);
        check("p_final_dout", bus_p.data_out, 32'h5A);
        check("n_final_dout", bus_n.data_out, 32'h81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/byte_deserializer.md
BYTE_DESERIALIZER -- requirements
Module: byte_deserializer

Interface
REQ-001 Parameter PARITY_EN, default 1: 1 = frame carries an even-parity bit; 0 = no parity bit.
REQ-002 clk  input  1  Single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous, active-low.
REQ-004 bit_valid  input  1  One-cycle strobe; sin is sampled only in cycles where bit_valid=1.
REQ-005 sin  input  1  Serial data; idles high.
REQ-006 data_out  output  8  Last good received byte; feeds the downstream 8-bit enabled register's data input.
REQ-007 load_en  output  1  One-cycle pulse when data_out holds a new good byte; drives the downstream register's enable.
REQ-008 busy  output  1  High whenever the FSM is not IDLE.
REQ-009 parity_err  output  1  One-cycle pulse when a frame ends with a parity mismatch.
REQ-010 frame_err  output  1  One-cycle pulse when the stop bit is sampled as 0.

Function
REQ-011 Frame format: start bit (0), 8 data bits LSB first, parity bit (only if PARITY_EN=1), stop bit (1).
REQ-012 The FSM SHALL have states IDLE, DATA, PARITY and STOP; transitions occur only in cycles with bit_valid=1.
REQ-013 IDLE: sin=0 moves to DATA and clears the bit counter; sin=1 stays in IDLE.
REQ-014 DATA: each sample shifts into an 8-bit shift register, LSB first; after the 8th sample go to PARITY if PARITY_EN=1, else STOP.
REQ-015 PARITY: the sampled bit is compared with the XOR of the 8 data bits (even parity), the mismatch is latched, and the FSM goes to STOP.
REQ-016 STOP: the FSM returns to IDLE on the sample, whatever its value.
REQ-017 Good frame (stop=1, no parity mismatch): data_out SHALL be updated with the shifted byte and load_en pulses high for exactly 1 cycle; both happen in the cycle after the stop sample.
REQ-018 Stop sampled 0: frame_err pulses, load_en stays low, and data_out holds its previous value.
REQ-019 Parity mismatch with stop=1: parity_err pulses, load_en stays low, and data_out holds.
REQ-020 Parity mismatch with stop=0: both error flags pulse in the same cycle, with no load.
REQ-021 Error and load pulses SHALL all align to the same cycle, the one after the stop sample.
REQ-022 Back-to-back frames: a start bit sampled in the cycle that load_en is high SHALL be accepted with no dropped frame.
REQ-023 bit_valid on consecutive cycles SHALL be supported; there is no minimum gap between strobes.
REQ-024 With bit_valid=0, the FSM, counter and shift register hold indefinitely; there is no timeout.
REQ-025 The bit counter is 3 bits and wraps from 7 to 0 exactly as DATA exits.
REQ-026 busy SHALL be high from the cycle after the start sample through the stop sample cycle.

Reset
REQ-027 On rst_n=0 (asynchronous assert): state=IDLE, counter=0, shift register=0x00, data_out=0x00, and load_en, busy, parity_err and frame_err are all 0.
REQ-028 Reset mid-frame SHALL discard the partial byte; no load_en or error pulse is produced.
REQ-029 After reset release, the first valid sample is treated as an IDLE sample.

Structure
REQ-030 The shared package SHALL hold: the FSM state enum (IDLE, DATA, PARITY, STOP), the constant DATA_BITS=8, and the constant STOP_LEVEL=1.
REQ-031 One sub-module is natural: frame_shifter, an 8-bit LSB-first shift register with shift enable that also provides the running XOR parity.
REQ-032 The FSM and output registering SHALL live in byte_deserializer; all outputs are registered.

Verification
REQ-033 Good frame: PARITY_EN=1; frame 0, bits of 0xA5 LSB first, parity 0, stop 1 -> data_out=0xA5 and a single load_en pulse the cycle after the stop sample.
REQ-034 Parity error: 0x07 with parity 0, stop 1 -> parity_err pulse; no load_en; data_out keeps 0xA5.
REQ-035 Framing error: 0x3C with correct parity 0, stop 0 -> frame_err pulse; no load; data_out unchanged.
REQ-036 Back-to-back frames with consecutive strobes: 0x11 then 0xEE, the second start bit sampled in the load_en cycle -> two load pulses, with data_out=0x11 then 0xEE.
REQ-037 Mid-frame reset: rst_n low after 4 data bits of 0xFF -> all outputs 0 immediately; a following 0x5A frame loads 0x5A.
REQ-038 PARITY_EN=0 with idle noise: sin=1 strobes in IDLE -> no busy; frame 0x81 with no parity bit -> load of 0x81.
